// File: rtl/dispatch_pkg.sv
// Shared dispatch definitions: opcode map, op classes, FSM states and the dispatch bus layout.
// Imported by the dispatch controller and the commit-side decoder.
package dispatch_pkg;

  localparam logic [4:0] OP_NOP  = 5'h1F;
  localparam logic [4:0] OP_HALT = 5'h1E;
  localparam logic [4:0] ALU_MAX = 5'd21;
  localparam logic [4:0] MEM_MIN = 5'd22;
  localparam logic [4:0] MEM_MAX = 5'd29;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MEM,
    CLS_HALT,
    CLS_NOP
  } op_class_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_FLUSH
  } state_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } dis_bus_t;

  // Classes that occupy a ROB entry when dispatched.
  function automatic logic needs_rob(input op_class_t cls);
    return (cls == CLS_ALU) || (cls == CLS_MEM) || (cls == CLS_HALT);
  endfunction

endpackage

// File: rtl/dispatch_op_classifier.sv
// Opcode to op-class decode; purely combinational, no backpressure.
// Shared between dispatch and commit so both agree on the opcode map.
module op_classifier
  import dispatch_pkg::*;
(
  input  logic [4:0] op,
  output op_class_t  op_class
);

  always_comb begin
    op_class = CLS_NOP;
    if (op <= ALU_MAX) begin
      op_class = CLS_ALU;
    end else if ((op >= MEM_MIN) && (op <= MEM_MAX)) begin
      op_class = CLS_MEM;
    end else if (op == OP_HALT) begin
      op_class = CLS_HALT;
    end
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Pops the instruction queue, allocates ROB tags and steers ops to RS/LSB; issue is 1 cycle after accept.
// Pop is withheld while any required downstream full flag is high, during flush, and in HALT.
module dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter  int ROB_DEPTH = 16,
  localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iq_valid,
  input  logic [4:0]       iq_op,
  input  logic [4:0]       iq_rs1,
  input  logic [4:0]       iq_rs2,
  input  logic [4:0]       iq_rd,
  input  logic [31:0]      iq_imm,
  output logic             iq_ready,
  input  logic             rob_full,
  input  logic             rs_full,
  input  logic             lsb_full,
  input  logic             flush,
  input  logic [TAG_W-1:0] flush_tag,
  output logic             iq_flush,
  output logic             rob_alloc,
  output logic             rs_issue,
  output logic             lsb_issue,
  output logic [4:0]       dis_op,
  output logic [4:0]       dis_rs1,
  output logic [4:0]       dis_rs2,
  output logic [4:0]       dis_rd,
  output logic [31:0]      dis_imm,
  output logic [TAG_W-1:0] dis_tag,
  output logic             halted
);

  state_t           state;
  state_t           state_nxt;
  op_class_t        head_cls;
  logic [TAG_W-1:0] next_tag;
  logic             room_ok;
  logic             accept;
  dis_bus_t         dis_q;

  op_classifier u_classifier (
    .op       (iq_op),
    .op_class (head_cls)
  );

  // Full flags are sampled directly; downstream slack absorbs the registered issue.
  always_comb begin
    room_ok = 1'b0;
    case (head_cls)
      CLS_NOP:  room_ok = 1'b1;
      CLS_ALU:  room_ok = !rob_full && !rs_full;
      CLS_MEM:  room_ok = !rob_full && !lsb_full;
      CLS_HALT: room_ok = !rob_full;
      default:  room_ok = 1'b0;
    endcase
  end

  assign iq_ready = (state == S_RUN) && !flush && room_ok;
  assign accept   = iq_valid && iq_ready;
  assign halted   = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_FLUSH;
    end else begin
      case (state)
        S_RUN:   if (accept && (head_cls == CLS_HALT)) state_nxt = S_HALT;
        S_HALT:  state_nxt = S_HALT;
        S_FLUSH: state_nxt = S_RUN;
        default: state_nxt = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next_tag  <= '0;
      rob_alloc <= 1'b0;
      rs_issue  <= 1'b0;
      lsb_issue <= 1'b0;
      iq_flush  <= 1'b0;
      dis_q     <= '0;
      dis_tag   <= '0;
    end else begin
      rob_alloc <= 1'b0;
      rs_issue  <= 1'b0;
      lsb_issue <= 1'b0;
      iq_flush  <= flush;
      if (flush) begin
        next_tag <= flush_tag;
      end else if (accept && needs_rob(head_cls)) begin
        rob_alloc <= 1'b1;
        rs_issue  <= (head_cls == CLS_ALU);
        lsb_issue <= (head_cls == CLS_MEM);
        dis_q     <= '{op: iq_op, rs1: iq_rs1, rs2: iq_rs2, rd: iq_rd, imm: iq_imm};
        dis_tag   <= next_tag;
        // ROB_DEPTH is a power of two, so the tag wraps by natural overflow.
        next_tag  <= next_tag + TAG_W'(1);
      end
    end
  end

  assign dis_op  = dis_q.op;
  assign dis_rs1 = dis_q.rs1;
  assign dis_rs2 = dis_q.rs2;
  assign dis_rd  = dis_q.rd;
  assign dis_imm = dis_q.imm;

endmodule

// File: doc/dispatch_ctrl.md
# dispatch_ctrl

- Sequences the instruction queue into the back end: pops the queue head, allocates a ROB tag, and steers the instruction to the ALU reservation station (RS) or the load/store buffer (LSB).
- Stalls on any downstream full condition, drops NOP bubbles, stops dispatch on HALT, and recovers from a flush.
- Sits between the instruction queue and the ROB/RS/LSB; all dispatch outputs are registered.

## Interface
- ROB_DEPTH, 16, ROB entries; power of two. localparam TAG_W = $clog2(ROB_DEPTH).
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- iq_valid  in  1  queue head holds a valid instruction.
- iq_op, iq_rs1, iq_rs2, iq_rd  in  5 each  head instruction fields.
- iq_imm  in  32  head immediate.
- iq_ready  out  1  pop strobe; handshake = iq_valid && iq_ready.
- rob_full, rs_full, lsb_full  in  1 each  downstream full flags, each with ≥1 entry of slack.
- flush  in  1  mispredict/exception flush request.
- flush_tag  in  TAG_W  first tag to allocate after the flush.
- iq_flush  out  1  one-cycle clear pulse to the queue.
- rob_alloc  out  1  ROB entry allocate strobe.
- rs_issue, lsb_issue  out  1 each  write strobes; mutually exclusive.
- dis_op, dis_rs1, dis_rs2, dis_rd  out  5 each  shared dispatch bus.
- dis_imm  out  32  shared dispatch bus.
- dis_tag  out  TAG_W  ROB tag of the dispatched instruction.
- halted  out  1  high while in the HALT state.

## Operation
- **States:** RUN, HALT, FLUSH.
- **Op classes:**
  - ALU: op 0–21, routed to RS.
  - MEM: op 22–29, routed to LSB.
  - HALT: op 30.
  - NOP: op 31.
- **iq_ready (combinational)** = state==RUN && !flush && one of:
  - op is NOP;
  - !rob_full, and also !rs_full for ALU or !lsb_full for MEM;
  - !rob_full for HALT.
- **Accepted ALU/MEM:**
  - next cycle: rob_alloc=1 plus rs_issue or lsb_issue, with the dis_* bus loaded and dis_tag = next_tag;
  - next_tag then increments, wrapping ROB_DEPTH-1 → 0.
- **Accepted HALT:**
  - next cycle: rob_alloc=1 with dis_tag, no RS/LSB issue;
  - next_tag increments;
  - state → HALT.
- **Accepted NOP:** popped only; no strobes, next_tag unchanged.
- **HALT state:** iq_ready=0 and halted=1. Leaves only on flush or rst.
- **flush=1 in any state:**
  - no accept that cycle;
  - next cycle all issue strobes are 0 and iq_flush=1;
  - next_tag ← flush_tag;
  - state → FLUSH for exactly one cycle, then RUN.
- **flush during FLUSH:** re-enters FLUSH and reloads next_tag.
- **Strobe width:** all strobes are single-cycle. dis_* hold their last value when no strobe is asserted.
- **Reset:**
  - state=RUN, next_tag=0;
  - all strobes, iq_flush and halted = 0;
  - dis_* = 0.

## Timing
- Accept-to-issue latency is 1 cycle; peak throughput 1 instruction per cycle.
- Full flags are sampled combinationally in the accept cycle. The block does not count in-flight entries; the 1-entry slack covers the registered issue.
- flush wins over a simultaneous valid head; that instruction stays in the queue and is then cleared by iq_flush.
- rst wins over flush. A reset mid-stall or mid-HALT returns to RUN with tag 0 on the next edge.
- Tag wrap is pure modulo ROB_DEPTH; ROB occupancy is guarded by rob_full.

## Structure
- Package dispatch_pkg holds:
  - OP_NOP=5'h1F, OP_HALT=5'h1E;
  - ALU_MAX=21, MEM_MIN=22, MEM_MAX=29;
  - op_class_t enum {CLS_ALU, CLS_MEM, CLS_HALT, CLS_NOP};
  - state_t enum {S_RUN, S_HALT, S_FLUSH}.
- One combinational sub-module, op_classifier: iq_op → op_class_t, shared with the commit side.

## Test plan
- **Reset, then ALU op 5 (rd=3) with all fulls low:** iq_ready=1; next cycle rob_alloc=1, rs_issue=1, dis_rd=3, dis_tag=0.
- **Back-to-back MEM op 22, ALU op 0, MEM op 29:** tags 0,1,2; lsb_issue, rs_issue, lsb_issue on consecutive cycles.
- **MEM op 23 with lsb_full=1 for 3 cycles:** iq_ready=0 for those cycles; issue appears 1 cycle after lsb_full drops.
- **Tag wrap, ROB_DEPTH=16:** 17 ALU ops give dis_tag 15 on the 16th and 0 on the 17th.
- **NOP then HALT:** NOP consumes a cycle with no strobes. HALT gives rob_alloc=1 and halted=1. A following ALU op is never accepted.
- **flush with flush_tag=9 while iq_valid=1 and in HALT:** iq_ready=0 that cycle; next cycle iq_flush=1 and no issue. The cycle after, state is RUN, and the next ALU op gets dis_tag=9.
